// File: rtl/immediate_insert.sv
// -----------------------------------------------------------------------------
// immediate_insert
//
// Inserts an immediate value into the immediate fields of a 32-bit RISC-V style
// instruction word. Every bit that does not belong to the selected immediate
// field is copied from the base word. The result is flagged when the immediate
// cannot be represented in that field.
//
// Pipeline: S1 registers the request and S2 registers the encoded result. An
// accepted request reaches out_valid two cycles later when nothing stalls.
// Both stages use valid/ready handshakes, so a stalled consumer backs up into
// S1 and then into in_ready without dropping or duplicating a request.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   request presented
//   in_ready   block can accept a request this cycle
//   base       instruction word that supplies the non-immediate bits
//   imm        immediate value to encode
//   select     [2:0] format: 000 U, 001 J, 010 I, 011 B, 100 S, 101 shamt
//              [3]   unsigned flag (ignored for shamt)
//   out_valid  inst/error hold a result
//   out_ready  consumer accepts the result
//   inst       encoded instruction
//   error      immediate not representable, or reserved format 110/111
//   err_count  saturating count of results delivered with error set
// -----------------------------------------------------------------------------
module immediate_insert #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          base,
  input  logic [31:0]          imm,
  input  logic [3:0]           select,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          inst,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Immediate formats. The two reserved codes are named so that the case
  // statement covers the full 3-bit space explicitly.
  typedef enum logic [2:0] {
    FMT_U     = 3'b000,
    FMT_J     = 3'b001,
    FMT_I     = 3'b010,
    FMT_B     = 3'b011,
    FMT_S     = 3'b100,
    FMT_SHAMT = 3'b101,
    FMT_RSV6  = 3'b110,
    FMT_RSV7  = 3'b111
  } fmt_e;

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic        s1_valid;
  logic [31:0] s1_base;
  logic [31:0] s1_imm;
  logic [3:0]  s1_sel;

  logic s2_load;     // S2 takes a new value (possibly a bubble) this cycle
  logic s1_advance;  // S1 contents move into S2 this cycle
  logic in_fire;     // input transfer
  logic out_fire;    // output transfer

  assign out_fire   = out_valid && out_ready;
  assign s2_load    = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples the values from before the edge.
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the payload registers are not reset; s1_valid alone says whether
  // they hold anything, so clearing them on reset would only add reset fanout.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_base <= base;
      s1_imm  <= imm;
      s1_sel  <= select;
    end
  end

  // ---------------------------------------------------------------------------
  // Encoder: combinational from the S1 registers
  // ---------------------------------------------------------------------------
  fmt_e        fmt;
  logic        uns;
  logic        fits_s12;  // imm is a 12-bit two's-complement value
  logic        fits_u12;  // imm is a 12-bit unsigned value
  logic        fits12;    // range rule shared by the I and S formats
  logic [31:0] enc_inst;
  logic        enc_err;

  assign fmt      = fmt_e'(s1_sel[2:0]);
  assign uns      = s1_sel[3];
  assign fits_s12 = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign fits_u12 = !(|s1_imm[31:12]);
  assign fits12   = uns ? fits_u12 : fits_s12;

  always_comb begin
    // NOTE: defaults come first so every path assigns both outputs and no
    // latch is inferred; each format then overwrites only its own fields.
    enc_inst = s1_base;
    enc_err  = 1'b0;
    case (fmt)
      FMT_U: begin
        enc_inst[31:12] = s1_imm[31:12];
        enc_err         = |s1_imm[11:0];
      end
      FMT_J: begin
        if (uns) begin
          enc_inst[31:12] = s1_imm[20:1];
        end else begin
          enc_inst[31]    = s1_imm[20];
          enc_inst[30:21] = s1_imm[10:1];
          enc_inst[20]    = s1_imm[11];
          enc_inst[19:12] = s1_imm[19:12];
        end
        // Jump targets are even and limited to 21 bits.
        enc_err = s1_imm[0] || (|s1_imm[31:21]);
      end
      FMT_I: begin
        enc_inst[31:20] = s1_imm[11:0];
        enc_err         = !fits12;
      end
      FMT_B: begin
        if (uns) begin
          enc_inst[31:25] = s1_imm[12:6];
          enc_inst[11:7]  = s1_imm[5:1];
        end else begin
          enc_inst[31]    = s1_imm[12];
          enc_inst[30:25] = s1_imm[10:5];
          enc_inst[11:8]  = s1_imm[4:1];
          enc_inst[7]     = s1_imm[11];
        end
        // Branch offsets are even and limited to 13 bits.
        enc_err = s1_imm[0] || (|s1_imm[31:13]);
      end
      FMT_S: begin
        enc_inst[31:25] = s1_imm[11:5];
        enc_inst[11:7]  = s1_imm[4:0];
        enc_err         = !fits12;
      end
      FMT_SHAMT: begin
        enc_inst[29:25] = s1_imm[4:0];
        enc_err         = |s1_imm[31:5];
      end
      FMT_RSV6, FMT_RSV7: begin
        enc_err = 1'b1;  // base passes through unchanged
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2: result register. It is only written when it is empty or draining,
  // so inst/error stay frozen while the consumer stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      inst      <= '0;
      error     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        inst  <= enc_inst;
        error <= enc_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter: counts delivered results with error set, sticks at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (out_fire && error && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_immediate_insert.sv
// -----------------------------------------------------------------------------
// tb_immediate_insert
//
// Directed bench for immediate_insert: reset state, hand-computed encodings for
// every format including error cases, a stalled back-to-back stream, counter
// saturation, reset with requests in flight, and a randomized round-trip pass
// that decodes each error-free result and compares it with the request.
// -----------------------------------------------------------------------------
module tb_immediate_insert;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base;
  logic [31:0] imm;
  logic [3:0]  select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        error;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  immediate_insert #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base      (base),
    .imm       (imm),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .error     (error),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One request through an empty pipeline with out_ready held high.
  task automatic run_one(input logic [31:0] b, input logic [31:0] i, input logic [3:0] s,
                         output logic [31:0] o_inst, output logic o_err);
    int lat;
    base      = b;
    imm       = i;
    select    = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;  // accept edge
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    o_inst = inst;
    o_err  = error;
    @(posedge clk); #1;  // output transfer edge
  endtask

  task automatic dir(input string tag, input logic [31:0] b, input logic [31:0] i,
                     input logic [3:0] s, input logic [31:0] exp_inst, input logic exp_err);
    logic [31:0] o_inst;
    logic        o_err;
    run_one(b, i, s, o_inst, o_err);
    check({tag, "_inst"}, o_inst, exp_inst);
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
  endtask

  // Independent decoder: pulls the immediate back out of an encoded word.
  function automatic logic [31:0] decode(input logic [31:0] w, input logic [3:0] s);
    case (s[2:0])
      3'b000: return {w[31:12], 12'b0};
      3'b001: return s[3] ? {11'b0, w[31:12], 1'b0}
                          : {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'b010: return s[3] ? {20'b0, w[31:20]} : {{20{w[31]}}, w[31:20]};
      3'b011: return s[3] ? {19'b0, w[31:25], w[11:7], 1'b0}
                          : {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'b100: return s[3] ? {20'b0, w[31:25], w[11:7]} : {{20{w[31]}}, w[31:25], w[11:7]};
      3'b101: return {27'b0, w[29:25]};
      default: return w;
    endcase
  endfunction

  // Bits of the word that belong to the immediate field of each format.
  function automatic logic [31:0] field_mask(input logic [3:0] s);
    case (s[2:0])
      3'b000, 3'b001: return 32'hFFFF_F000;
      3'b010:         return 32'hFFF0_0000;
      3'b011, 3'b100: return 32'hFE00_0F80;
      3'b101:         return 32'h3E00_0000;
      default:        return 32'h0000_0000;
    endcase
  endfunction

  initial begin
    logic [31:0] r_base, r_imm, r_inst, m;
    logic [3:0]  r_sel;
    logic        r_err;
    int          shift;
    int          sat_extra;
    int          ghost;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    base      = '0;
    imm       = '0;
    select    = '0;

    // ---------------- reset state ----------------
    repeat (2) begin @(posedge clk); #1; end
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ---------------- directed encodings ----------------
    dir("i_neg",      32'h0000_0013, 32'hFFFF_F800, 4'b0010, 32'h8000_0013, 1'b0);
    dir("b_max",      32'h0000_0063, 32'h0000_1FFE, 4'b0011, 32'hFE00_0FE3, 1'b0);
    dir("b_odd",      32'h0000_0063, 32'h0000_0003, 4'b0011, 32'h0000_0163, 1'b1);
    check("err_count_1", 32'(err_count), 32'd1);
    dir("u_ok",       32'h0000_0037, 32'h1234_5000, 4'b0000, 32'h1234_5037, 1'b0);
    dir("u_low",      32'h0000_0037, 32'h1234_5001, 4'b0000, 32'h1234_5037, 1'b1);
    dir("j_s",        32'h0000_006F, 32'h000F_FFFE, 4'b0001, 32'h7FFF_F06F, 1'b0);
    dir("j_u",        32'h0000_006F, 32'h0000_0802, 4'b1001, 32'h0040_106F, 1'b0);
    dir("j_range",    32'h0000_006F, 32'h0020_0000, 4'b0001, 32'h0000_006F, 1'b1);
    dir("i_u_max",    32'h0000_0013, 32'h0000_0FFF, 4'b1010, 32'hFFF0_0013, 1'b0);
    dir("i_u_over",   32'h0000_0013, 32'h0000_1000, 4'b1010, 32'h0000_0013, 1'b1);
    dir("i_s_over",   32'h0000_0013, 32'h0000_0800, 4'b0010, 32'h8000_0013, 1'b1);
    dir("i_s_under",  32'h0000_0013, 32'hFFFF_F7FF, 4'b0010, 32'h7FF0_0013, 1'b1);
    dir("i_keep",     32'hFFFF_FFFF, 32'h0000_0000, 4'b0010, 32'h000F_FFFF, 1'b0);
    dir("s_neg1",     32'h0000_0023, 32'hFFFF_FFFF, 4'b0100, 32'hFE00_0FA3, 1'b0);
    dir("s_u_max",    32'h0000_0023, 32'h0000_0FFF, 4'b1100, 32'hFE00_0FA3, 1'b0);
    dir("shamt_31",   32'h0000_5013, 32'h0000_001F, 4'b0101, 32'h3E00_5013, 1'b0);
    dir("shamt_32",   32'h0000_5013, 32'h0000_0020, 4'b1101, 32'h0000_5013, 1'b1);
    dir("rsv6",       32'hDEAD_BEEF, 32'h0000_0000, 4'b0110, 32'hDEAD_BEEF, 1'b1);
    dir("rsv7",       32'hDEAD_BEEF, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    dir("b_u_max",    32'h0000_0000, 32'h0000_1FFE, 4'b1011, 32'hFE00_0F80, 1'b0);
    dir("b_range",    32'h0000_0063, 32'h0000_2000, 4'b0011, 32'h0000_0063, 1'b1);
    check("err_count_10", 32'(err_count), 32'd10);

    // ---------------- back-to-back stream with a stalled consumer ----------------
    begin
      logic [31:0] held;
      bit          holding;
      bit          saw_full;
      int          sent;
      int          got;
      int          extra;
      holding  = 1'b0;
      saw_full = 1'b0;
      sent     = 0;
      got      = 0;
      extra    = 0;
      held     = '0;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
        bit acc;
        out_ready = !(cyc >= 3 && cyc <= 6);
        in_valid  = (sent < 8);
        base      = 32'h13 | (sent << 7);
        imm       = 32'(sent + 1);
        select    = 4'b0010;
        #1;
        acc = in_valid && in_ready;
        if (!in_ready) saw_full = 1'b1;
        if (out_valid) begin
          if (holding) check("stall_stable", inst, held);
          if (out_ready) begin
            check("stall_order", inst, 32'(32'h13 | (got << 7) | ((got + 1) << 20)));
            got++;
            holding = 1'b0;
          end else begin
            holding = 1'b1;
            held    = inst;
          end
        end
        @(posedge clk); #1;
        if (acc) sent++;
      end
      in_valid = 1'b0;
      check("stall_count", 32'(got), 32'd8);
      check("stall_full", 32'(saw_full), 32'd1);
      repeat (4) begin
        @(posedge clk); #1;
        if (out_valid) extra++;
      end
      check("stall_extra", 32'(extra), 32'd0);
    end

    // ---------------- error counter saturation ----------------
    base      = 32'h0000_0000;
    imm       = 32'h0000_0000;
    select    = 4'b0110;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (300) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("err_sat", 32'(err_count), 32'h0000_00FF);
    dir("sat_more", 32'h0000_0013, 32'h0000_1000, 4'b1010, 32'h0000_0013, 1'b1);
    check("err_sat_hold", 32'(err_count), 32'h0000_00FF);
    sat_extra = 0;

    // ---------------- reset with two requests in flight ----------------
    out_ready = 1'b0;
    select    = 4'b0110;
    in_valid  = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("flight_out_valid", 32'(out_valid), 32'd1);
    check("flight_in_ready", 32'(in_ready), 32'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_inst", inst, 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    ghost = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) ghost++;
    end
    check("mid_rst_no_output", 32'(ghost), 32'(sat_extra));
    check("mid_rst_err_after", 32'(err_count), 32'd0);

    // ---------------- randomized round trip ----------------
    for (int n = 0; n < 10000; n++) begin
      r_base = $urandom;
      r_sel  = 4'($urandom_range(0, 15));
      shift  = $urandom_range(0, 31);
      r_imm  = $urandom >> shift;
      if ($urandom_range(0, 1) == 1) r_imm = ~r_imm;
      if ($urandom_range(0, 1) == 1) r_imm = r_imm & 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) == 0) r_imm = r_imm & 32'hFFFF_F000;
      run_one(r_base, r_imm, r_sel, r_inst, r_err);
      m = field_mask(r_sel);
      if (!r_err) begin
        check("rt_imm", decode(r_inst, r_sel), r_imm);
        check("rt_base", r_inst & ~m, r_base & ~m);
      end else if (r_sel[2:1] == 2'b11) begin
        check("rt_rsv", r_inst, r_base);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
